// File: rtl/pic_pkg.sv
// Shared definitions for the N-channel interrupt controller.
package pic_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_ACK1,
    ST_WAIT2,
    ST_VECT
  } pic_state_e;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_IMR  = 3'd1;
  localparam logic [2:0] A_TRIG = 3'd2;
  localparam logic [2:0] A_IRR  = 3'd3;
  localparam logic [2:0] A_ISR  = 3'd4;
  localparam logic [2:0] A_EOI  = 3'd5;
  localparam logic [2:0] A_PRIO = 3'd6;

  localparam int CTRL_ROT  = 0;
  localparam int CTRL_AEOI = 1;
endpackage

// File: rtl/pic_prio_arb.sv
// Combinational priority arbiter: picks the highest-priority request that
// outranks every in-service line, in fixed or rotating order.
module pic_prio_arb #(
  parameter int N_IRQ = 8,
  localparam int PW = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [N_IRQ-1:0] isr,
  input  logic             rotate_en,
  input  logic [PW-1:0]    prio_ptr,
  output logic [PW-1:0]    sel_idx,
  output logic             any
);
  // Rank 0 is highest. Rotating mode puts the line after prio_ptr at rank 0.
  function automatic int rank(input int i, input logic rot, input logic [PW-1:0] p);
    int r;
    if (!rot) return i;
    r = i + N_IRQ - 1 - int'(p);
    if (r >= N_IRQ) r = r - N_IRQ;
    return r;
  endfunction

  // Find the best in-service rank, then the best request strictly above it.
  always_comb begin
    int isr_top;
    int best;
    int r;
    isr_top = N_IRQ;
    best    = N_IRQ;
    r       = 0;
    sel_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      r = rank(i, rotate_en, prio_ptr);
      if (isr[i] && r < isr_top) isr_top = r;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      r = rank(i, rotate_en, prio_ptr);
      if (req[i] && r < isr_top && r < best) begin
        best    = r;
        sel_idx = PW'(i);
        any     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pic_nchan.sv
// Programmable interrupt controller: registers, edge detect, INTA FSM, read mux.
module pic_nchan
  import pic_pkg::*;
#(
  parameter int         N_IRQ    = 8,
  parameter logic [7:0] VEC_BASE = 8'hA0,
  parameter logic [7:0] SPUR_VEC = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic [N_IRQ-1:0] wdata,
  output logic [N_IRQ-1:0] rdata,
  input  logic [N_IRQ-1:0] intreq,
  input  logic             intackN,
  output logic             int_out,
  output logic [7:0]       vec_out,
  output logic             vec_valid
);
  localparam int PW = $clog2(N_IRQ);

  pic_state_e       r_state, w_next;
  logic [1:0]       r_ctrl;
  logic [N_IRQ-1:0] r_imr, r_trig, r_irr, r_isr, r_prev;
  logic [PW-1:0]    r_prio, r_sel;
  logic             r_spur, r_int_out;

  logic [PW-1:0]    w_sel;
  logic             w_any, w_ack, w_ack_real, w_vexit, w_aeoi, w_eoi_v;
  logic [4:0]       w_eoi_idx;
  logic [N_IRQ-1:0] w_sel_oh, w_set, w_irr_clr, w_eoi_clr, w_aeoi_clr, w_isr_clr;

  pic_prio_arb #(.N_IRQ(N_IRQ)) u_arb (
    .req      (r_irr & r_imr),
    .isr      (r_isr),
    .rotate_en(r_ctrl[CTRL_ROT]),
    .prio_ptr (r_prio),
    .sel_idx  (w_sel),
    .any      (w_any)
  );

  // EOI index is 5 bits wide even when the data bus is narrower.
  if (N_IRQ >= 5) begin : g_idx_wide
    assign w_eoi_idx = wdata[4:0];
  end else begin : g_idx_narrow
    assign w_eoi_idx = 5'(wdata);
  end

  assign w_ack      = (r_state == ST_PEND) && !intackN;
  assign w_ack_real = w_ack && w_any;
  assign w_vexit    = (r_state == ST_VECT) && intackN;
  assign w_aeoi     = w_vexit && r_ctrl[CTRL_AEOI] && !r_spur;
  assign w_sel_oh   = N_IRQ'(1) << w_sel;

  // Level lines follow intreq until acked; edge lines latch rising edges.
  assign w_set     = r_imr & ((r_trig & intreq & ~r_prev) | (~r_trig & intreq));
  assign w_irr_clr = (~r_trig & ~intreq)
                   | ((wr_en && addr == A_IRR) ? wdata : '0)
                   | (w_ack_real ? w_sel_oh : '0);

  // EOI command and auto-EOI may hit the same bit; OR-ing clears it once.
  assign w_eoi_v    = wr_en && (addr == A_EOI) && (int'(w_eoi_idx) < N_IRQ);
  assign w_eoi_clr  = w_eoi_v ? (N_IRQ'(1) << w_eoi_idx) : '0;
  assign w_aeoi_clr = w_aeoi ? (N_IRQ'(1) << r_sel) : '0;
  assign w_isr_clr  = (w_eoi_clr | w_aeoi_clr) & r_isr;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Two-pulse INTA sequencing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any)    w_next = ST_PEND;
      ST_PEND:  if (!intackN) w_next = ST_ACK1;
      ST_ACK1:  if (intackN)  w_next = ST_WAIT2;
      ST_WAIT2: if (!intackN) w_next = ST_VECT;
      ST_VECT:  if (intackN)  w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // Registers, request/service tracking, latched selection and int_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_imr     <= '0;
      r_trig    <= '0;
      r_irr     <= '0;
      r_isr     <= '0;
      r_prev    <= '0;
      r_prio    <= PW'(N_IRQ - 1);
      r_sel     <= '0;
      r_spur    <= 1'b0;
      r_int_out <= 1'b0;
    end else begin
      r_prev <= intreq;
      if (wr_en && addr == A_CTRL) r_ctrl <= wdata[1:0];
      if (wr_en && addr == A_IMR)  r_imr  <= wdata;
      if (wr_en && addr == A_TRIG) r_trig <= wdata;
      r_irr <= (r_irr & ~w_irr_clr) | w_set;
      r_isr <= (r_isr & ~w_isr_clr) | (w_ack_real ? w_sel_oh : '0);
      if (w_aeoi && |w_aeoi_clr & r_isr) r_prio <= r_sel;
      else if (|(w_eoi_clr & r_isr))      r_prio <= PW'(w_eoi_idx);
      if (w_ack) begin
        r_sel  <= w_sel;
        r_spur <= !w_any;
      end
      if (r_state == ST_IDLE && w_any) r_int_out <= 1'b1;
      else if (w_vexit)                r_int_out <= 1'b0;
    end
  end

  assign int_out   = r_int_out;
  assign vec_valid = (r_state == ST_VECT);
  assign vec_out   = !vec_valid ? 8'h00 : (r_spur ? SPUR_VEC : VEC_BASE + 8'(r_sel));

  // Combinational register read-back.
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL: rdata = N_IRQ'(r_ctrl);
      A_IMR:  rdata = r_imr;
      A_TRIG: rdata = r_trig;
      A_IRR:  rdata = r_irr;
      A_ISR:  rdata = r_isr;
      A_PRIO: rdata = N_IRQ'(r_prio);
      default: rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_pic_nchan.sv
// Directed bench for pic_nchan (N_IRQ=8) with hand-computed expectations.
module tb_pic_nchan;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] addr = 3'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic [7:0] intreq = 8'h00;
  logic       intackN = 1'b1;
  logic       int_out;
  logic [7:0] vec_out;
  logic       vec_valid;

  int n_chk = 0;
  int n_pass = 0;

  pic_nchan #(.N_IRQ(8), .VEC_BASE(8'hA0), .SPUR_VEC(8'hFF)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .rdata(rdata), .intreq(intreq), .intackN(intackN), .int_out(int_out),
    .vec_out(vec_out), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chkreg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, 32'(rdata), 32'(exp));
  endtask

  // One edge pulse on intreq, then a cycle for int_out to register.
  task automatic pulse(input logic [7:0] m);
    intreq = m;
    tick();
    intreq = 8'h00;
    tick();
  endtask

  // Full two-pulse acknowledge; vector sampled in the VECT state.
  task automatic inta(output logic [7:0] v, output logic vv);
    intackN = 1'b0; tick();
    intackN = 1'b1; tick();
    intackN = 1'b0; tick();
    v = vec_out; vv = vec_valid;
    intackN = 1'b1; tick();
  endtask

  initial begin
    logic [7:0] v;
    logic       vv;
    tick(); tick();
    reset = 1'b0;
    chk("rst_int_out", 32'(int_out), 0);
    chk("rst_vec_valid", 32'(vec_valid), 0);
    chkreg("rst_irr", 3'd3, 8'h00);
    chkreg("rst_prio", 3'd6, 8'h07);

    // 1. fixed priority
    wr(3'd1, 8'hFF);
    wr(3'd2, 8'hFF);
    pulse(8'h24);
    chk("t1_int_out", 32'(int_out), 1);
    inta(v, vv);
    chk("t1_vec", 32'(v), 32'hA2);
    chk("t1_vv", 32'(vv), 1);
    chkreg("t1_isr", 3'd4, 8'h04);
    chkreg("t1_irr", 3'd3, 8'h20);
    chk("t1_nested_low", 32'(int_out), 0);
    wr(3'd5, 8'd2);
    tick();
    chk("t1_int_after_eoi", 32'(int_out), 1);
    inta(v, vv);
    chk("t1_vec2", 32'(v), 32'hA5);
    wr(3'd5, 8'd5);

    // 2. rotating priority
    wr(3'd0, 8'h01);
    pulse(8'h08);
    inta(v, vv);
    chk("t2_vec3", 32'(v), 32'hA3);
    wr(3'd5, 8'd3);
    chkreg("t2_prio", 3'd6, 8'h03);
    pulse(8'h14);
    inta(v, vv);
    chk("t2_vec4_first", 32'(v), 32'hA4);
    wr(3'd5, 8'd4);
    tick();
    inta(v, vv);
    chk("t2_vec2_next", 32'(v), 32'hA2);
    wr(3'd5, 8'd2);
    wr(3'd0, 8'h00);

    // 3. nesting
    pulse(8'h20);
    inta(v, vv);
    chk("t3_vec5", 32'(v), 32'hA5);
    pulse(8'h40);
    tick();
    chk("t3_irq6_blocked", 32'(int_out), 0);
    pulse(8'h02);
    chk("t3_irq1_int", 32'(int_out), 1);
    inta(v, vv);
    chk("t3_vec1", 32'(v), 32'hA1);
    wr(3'd5, 8'd31);
    chkreg("t3_eoi_oob", 3'd4, 8'h22);
    wr(3'd3, 8'hFF);
    wr(3'd5, 8'd1);
    wr(3'd5, 8'd5);
    chkreg("t3_isr_clean", 3'd4, 8'h00);

    // 4. level line dropped before ack -> spurious
    wr(3'd2, 8'hFE);
    intreq = 8'h01;
    tick(); tick();
    chk("t4_int_out", 32'(int_out), 1);
    intreq = 8'h00;
    tick();
    inta(v, vv);
    chk("t4_spur", 32'(v), 32'hFF);
    chk("t4_spur_vv", 32'(vv), 1);
    chkreg("t4_isr", 3'd4, 8'h00);

    // 5. auto-EOI, with a new edge on the acked line
    wr(3'd2, 8'hFF);
    wr(3'd0, 8'h02);
    pulse(8'h80);
    intackN = 1'b0; intreq = 8'h80;
    tick();
    chkreg("t5_irr_reset_edge", 3'd3, 8'h80);
    chkreg("t5_isr", 3'd4, 8'h80);
    intreq = 8'h00; intackN = 1'b1; tick();
    intackN = 1'b0; tick();
    chk("t5_vec7", 32'(vec_out), 32'hA7);
    intackN = 1'b1; tick();
    chkreg("t5_auto_eoi", 3'd4, 8'h00);
    chk("t5_int_cleared", 32'(int_out), 0);

    // 6. reset in WAIT2 (irq 7 still pending and gets served)
    tick();
    intackN = 1'b0; tick();
    intackN = 1'b1; tick();
    chk("t6_int_before", 32'(int_out), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_int_out", 32'(int_out), 0);
    chk("t6_vec_valid", 32'(vec_valid), 0);
    chkreg("t6_irr", 3'd3, 8'h00);
    chkreg("t6_isr", 3'd4, 8'h00);
    chkreg("t6_imr", 3'd1, 8'h00);
    intackN = 1'b0; tick();
    chk("t6_idle_no_vec", 32'(vec_valid), 0);
    chk("t6_idle_int", 32'(int_out), 0);
    intackN = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
